// File: rtl/j1_io_pkg.sv
// j1_io_pkg: shared definitions for the j1 I/O-bus UART peripheral.
//   - Register offsets within the 8-byte window (word offset = io_addr[2:1]).
//   - STATUS register bit positions.
//   - Common serial FSM state type used by the TX and RX engines.
//   - Smallest legal baud divisor.
package j1_io_pkg;

  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_DIV    = 2'd2;

  localparam int ST_RX_VALID     = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_TX_ACTIVE    = 2;
  localparam int ST_RX_OVERRUN   = 3;
  localparam int ST_RX_FRAME_ERR = 4;

  // Below this the RX mid-bit and resample arithmetic has no slack.
  localparam logic [15:0] DIV_MIN = 16'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/j1_uart_rx.sv
// j1_uart_rx: 8N1 deserialiser.
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   div_i              clocks per bit minus 1 (sampled at each counter reload)
//   rxd_i              asynchronous serial input
//   byte_vld_o         one-cycle pulse: a complete frame was received
//   byte_o             received byte, valid with byte_vld_o
//   frame_err_o        stop bit was 0, valid with byte_vld_o
module j1_uart_rx
  import j1_io_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] div_i,
  input  logic        rxd_i,
  output logic        byte_vld_o,
  output logic [7:0]  byte_o,
  output logic        frame_err_o
);

  uart_state_t state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        sync1_q;
  logic        sync2_q;
  logic        prev_q;
  logic        vld_q;
  logic [7:0]  byte_q;
  logic        ferr_q;

  logic bit_done;

  assign bit_done = (baud_q == 16'd0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // Synchroniser resets to the idle line level so release is not a start.
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      vld_q   <= 1'b0;
      byte_q  <= 8'd0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      vld_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          // Falling edge: wait half a bit to land in the middle of START.
          if (prev_q && !sync2_q) begin
            baud_q  <= div_i >> 1;
            state_q <= START;
          end
        end
        START: begin
          if (bit_done) begin
            if (sync2_q) begin
              state_q <= IDLE;
            end else begin
              baud_q  <= div_i;
              bit_q   <= 3'd0;
              state_q <= DATA;
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            shift_q <= {sync2_q, shift_q[7:1]};
            baud_q  <= div_i;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            vld_q   <= 1'b1;
            byte_q  <= shift_q;
            ferr_q  <= !sync2_q;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_vld_o  = vld_q;
  assign byte_o      = byte_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/j1_uart_tx.sv
// j1_uart_tx: 8N1 serialiser with a 1-deep holding register.
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   div_i              clocks per bit minus 1 (sampled at each bit reload)
//   wr_i, wr_data_i    byte write strobe and data
//   txd_o              registered serial output, idles high
//   tx_full_o          holding register occupied
//   tx_active_o        a frame is on the line (FSM not idle)
module j1_uart_tx
  import j1_io_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] div_i,
  input  logic        wr_i,
  input  logic [7:0]  wr_data_i,
  output logic        txd_o,
  output logic        tx_full_o,
  output logic        tx_active_o
);

  uart_state_t state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic [7:0]  hold_q;
  logic        full_q;
  logic        txd_q;

  logic bit_done;
  logic load;
  logic accept;

  assign bit_done = (baud_q == 16'd0);
  // Holding register drains either from idle, or straight at the end of a
  // stop bit so that a queued byte follows with no idle gap.
  assign load     = full_q && ((state_q == IDLE) || ((state_q == STOP) && bit_done));
  // A write is taken when the holder is empty or is emptying this very cycle.
  assign accept   = wr_i && (!full_q || load);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      hold_q  <= 8'd0;
      full_q  <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      if (accept) begin
        hold_q <= wr_data_i;
      end

      if (accept) begin
        full_q <= 1'b1;
      end else if (load) begin
        full_q <= 1'b0;
      end

      if (load) begin
        shift_q <= hold_q;
        baud_q  <= div_i;
        state_q <= START;
        txd_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            txd_q <= 1'b1;
          end
          START: begin
            if (bit_done) begin
              baud_q  <= div_i;
              bit_q   <= 3'd0;
              txd_q   <= shift_q[0];
              state_q <= DATA;
            end else begin
              baud_q <= baud_q - 16'd1;
            end
          end
          DATA: begin
            if (bit_done) begin
              baud_q <= div_i;
              if (bit_q == 3'd7) begin
                txd_q   <= 1'b1;
                state_q <= STOP;
              end else begin
                shift_q <= {1'b0, shift_q[7:1]};
                txd_q   <= shift_q[1];
                bit_q   <= bit_q + 3'd1;
              end
            end else begin
              baud_q <= baud_q - 16'd1;
            end
          end
          STOP: begin
            if (bit_done) begin
              txd_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              baud_q <= baud_q - 16'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign txd_o       = txd_q;
  assign tx_full_o   = full_q;
  assign tx_active_o = (state_q != IDLE);

endmodule

// File: rtl/j1_io_uart.sv
// j1_io_uart: memory-mapped UART responder on the j1 I/O bus.
// Ports:
//   sys_clk_i, sys_rst_n_i  clock, asynchronous active-low reset
//   io_rd, io_wr            CPU read / write strobes
//   io_addr                 byte address; window is BASE_ADDR..BASE_ADDR+7
//   io_dout                 CPU write data
//   io_din                  combinational read data, 0 when not selected
//   uart_rxd_i              asynchronous serial input
//   uart_txd_o              serial output
//   rx_irq_o                high while a received byte is waiting
// Registers (word offset io_addr[2:1]):
//   0 DATA    W: TX byte   R: {8'h00, rx_byte}, read pops rx_valid
//   1 STATUS  R: {rx_frame_err, rx_overrun, tx_active, tx_full, rx_valid},
//             read clears rx_frame_err and rx_overrun
//   2 DIVISOR R/W, writes below 3 stored as 3
//   3 reads 0
module j1_io_uart
  import j1_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hF000,
  parameter logic [15:0] DIV_RESET = 16'd433
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  input  logic        uart_rxd_i,
  output logic        uart_txd_o,
  output logic        rx_irq_o
);

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

  logic        sel;
  logic [1:0]  ofs;
  logic        addr_unused;
  logic        tx_wr;
  logic        div_wr;
  logic        pop;
  logic        stat_rd;

  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_ovr_q, rx_ovr_d;
  logic        rx_ferr_q, rx_ferr_d;
  logic [15:0] div_q, div_d;

  logic        tx_full;
  logic        tx_active;
  logic        rx_vld;
  logic [7:0]  rx_data;
  logic        rx_ferr;
  logic [15:0] status;

  // io_wr also strobes for RAM writes, so every action is gated by sel.
  assign sel         = (io_addr[15:3] == BASE_ADDR[15:3]);
  assign ofs         = io_addr[2:1];
  assign addr_unused = io_addr[0];
  assign tx_wr       = io_wr & sel & (ofs == OFS_DATA);
  assign div_wr      = io_wr & sel & (ofs == OFS_DIV);
  assign pop         = io_rd & sel & (ofs == OFS_DATA);
  assign stat_rd     = io_rd & sel & (ofs == OFS_STATUS);

  j1_uart_tx u_tx (
    .clk_i       (sys_clk_i),
    .rst_n_i     (sys_rst_n_i),
    .div_i       (div_q),
    .wr_i        (tx_wr),
    .wr_data_i   (io_dout[7:0]),
    .txd_o       (uart_txd_o),
    .tx_full_o   (tx_full),
    .tx_active_o (tx_active)
  );

  j1_uart_rx u_rx (
    .clk_i       (sys_clk_i),
    .rst_n_i     (sys_rst_n_i),
    .div_i       (div_q),
    .rxd_i       (uart_rxd_i),
    .byte_vld_o  (rx_vld),
    .byte_o      (rx_data),
    .frame_err_o (rx_ferr)
  );

  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_byte_d  = rx_byte_q;
    rx_ovr_d   = rx_ovr_q;
    rx_ferr_d  = rx_ferr_q;
    div_d      = div_q;

    if (stat_rd) begin
      rx_ovr_d  = 1'b0;
      rx_ferr_d = 1'b0;
    end

    // A delivery always wins: it refills rx_valid even when popped together,
    // and only an unconsumed byte being replaced counts as an overrun.
    if (rx_vld) begin
      rx_byte_d  = rx_data;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !pop) begin
        rx_ovr_d = 1'b1;
      end
      if (rx_ferr) begin
        rx_ferr_d = 1'b1;
      end
    end else if (pop) begin
      rx_valid_d = 1'b0;
    end

    if (div_wr) begin
      div_d = clamp_div(io_dout);
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      rx_valid_q <= 1'b0;
      rx_byte_q  <= 8'd0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      div_q      <= DIV_RESET;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
      div_q      <= div_d;
    end
  end

  always_comb begin
    status                  = 16'h0000;
    status[ST_RX_VALID]     = rx_valid_q;
    status[ST_TX_FULL]      = tx_full;
    status[ST_TX_ACTIVE]    = tx_active;
    status[ST_RX_OVERRUN]   = rx_ovr_q;
    status[ST_RX_FRAME_ERR] = rx_ferr_q;
  end

  // Read mux ignores io_rd so the CPU sees data in the strobe cycle itself.
  always_comb begin
    io_din = 16'h0000;
    if (sel) begin
      case (ofs)
        OFS_DATA:   io_din = {8'h00, rx_byte_q};
        OFS_STATUS: io_din = status;
        OFS_DIV:    io_din = div_q;
        default:    io_din = 16'h0000;
      endcase
    end
  end

  assign rx_irq_o = rx_valid_q;

endmodule
